// File: rtl/approx_mult_pkg.sv
// Shared widths and FSM state type for the approximate multiply/accumulate path.
package approx_mult_pkg;

  localparam int PROD_W = 15;
  localparam int OP_W   = 8;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/approx_dot_acc_sat_adder.sv
// Combinational saturating add of a zero-extended product onto a W-bit accumulator.
module sat_adder
  import approx_mult_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0]      a,
  input  logic [PROD_W-1:0] b,
  output logic [W-1:0]      y,
  output logic              ovf
);

  logic [W:0] sum;

  // One guard bit above the accumulator catches the carry-out.
  assign sum = {1'b0, a} + (W+1)'(b);
  assign ovf = sum[W];
  assign y   = ovf ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/approx_dot_acc.sv
// Frame accumulator for approximate products: saturating sum of up to LEN beats,
// result held on a valid/ready output until taken.
//
// state | meaning
// IDLE  | empty, waiting for the first beat of a frame
// ACCUM | frame open, summing beats until in_last or LEN beats
// DONE  | result presented, input stalled until the result is taken
module approx_dot_acc
  import approx_mult_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  state_t             state_q, state_nxt;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               sat_q, sat_nxt;
  logic               in_ready_q, out_valid_q;

  logic               accept, take;
  logic [CNT_W-1:0]   cnt_inc;
  logic               final_beat;
  logic [ACC_W-1:0]   add_y;
  logic               add_ovf;

  sat_adder #(.W(ACC_W)) u_sat_adder (
    .a   (acc_q),
    .b   (in_prod),
    .y   (add_y),
    .ovf (add_ovf)
  );

  assign accept     = in_valid && in_ready_q;
  assign take       = out_valid_q && out_ready;
  assign cnt_inc    = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  // in_last and the LEN limit close the same frame; either alone suffices.
  assign final_beat = in_last || (cnt_inc == CNT_W'(LEN));

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    sat_nxt   = sat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_nxt   = ACC_W'(in_prod);
          cnt_nxt   = cnt_inc;
          sat_nxt   = 1'b0;
          state_nxt = final_beat ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt = add_y;
          cnt_nxt = cnt_inc;
          sat_nxt = sat_q | add_ovf;
          if (final_beat) state_nxt = DONE;
        end
      end
      DONE: begin
        if (take) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      acc_q       <= acc_nxt;
      cnt_q       <= cnt_nxt;
      sat_q       <= sat_nxt;
      in_ready_q  <= (state_nxt != DONE);
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_approx_dot_acc.sv
// Four accumulator configurations on one shared stimulus stream, checked
// against an integer frame model plus directed scenario checks.
module tb_approx_dot_acc;

  localparam int NI = 4;
  localparam int LENS [NI] = '{4, 16, 3, 256};
  localparam int WS   [NI] = '{24, 24, 16, 24};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [14:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        rdy [NI];
  logic        vld [NI];
  logic [8:0]  cnt [NI];
  logic        sat [NI];
  logic [23:0] s0, s1, s3;
  logic [15:0] s2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  approx_dot_acc #(.LEN(4), .ACC_W(24)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(s0),
    .out_count(cnt[0]), .out_sat(sat[0]));
  approx_dot_acc #(.LEN(16), .ACC_W(24)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(s1),
    .out_count(cnt[1]), .out_sat(sat[1]));
  approx_dot_acc #(.LEN(3), .ACC_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(s2),
    .out_count(cnt[2]), .out_sat(sat[2]));
  approx_dot_acc #(.LEN(256), .ACC_W(24)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_sum(s3),
    .out_count(cnt[3]), .out_sat(sat[3]));

  function automatic longint sum_of(input int k);
    case (k)
      0: return longint'(s0);
      1: return longint'(s1);
      2: return longint'(s2);
      default: return longint'(s3);
    endcase
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a frame is an integer running sum clipped at 2^W-1.
  bit     m_rdy  [NI];
  bit     m_done [NI];
  longint m_acc  [NI];
  int     m_cnt  [NI];
  bit     m_sat  [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      longint maxv;
      maxv = (longint'(1) << WS[k]) - 1;
      if (!rst_n) begin
        m_done[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_rdy[k] = 0;
      end else begin
        if (m_done[k]) begin
          if (out_ready) begin
            m_done[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
          end
        end else if (in_valid && m_rdy[k]) begin
          m_acc[k] = m_acc[k] + longint'(in_prod);
          m_cnt[k] = m_cnt[k] + 1;
          if (m_acc[k] > maxv) begin
            m_acc[k] = maxv;
            m_sat[k] = 1;
          end
          if (in_last || m_cnt[k] == LENS[k]) m_done[k] = 1;
        end
        m_rdy[k] = !m_done[k];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("m_rdy%0d", k), longint'(rdy[k]), longint'(m_rdy[k]));
        check($sformatf("m_vld%0d", k), longint'(vld[k]), longint'(m_done[k]));
        if (m_done[k] || m_cnt[k] == 0) begin
          check($sformatf("m_sum%0d", k), sum_of(k), m_acc[k]);
          check($sformatf("m_cnt%0d", k), longint'(cnt[k]), longint'(m_cnt[k]));
          check($sformatf("m_sat%0d", k), longint'(sat[k]), longint'(m_sat[k]));
        end
      end
    end
  end

  task automatic cyc(input bit v, input int p, input bit l, input bit r);
    in_valid  = v;
    in_prod   = 15'(p);
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    longint held;
    rst_n = 1'b0; in_valid = 0; in_prod = '0; in_last = 0; out_ready = 0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_rdy", longint'(rdy[k]), 0);
      check("rst_vld", longint'(vld[k]), 0);
      check("rst_sum", sum_of(k), 0);
      check("rst_cnt", longint'(cnt[k]), 0);
      check("rst_sat", longint'(sat[k]), 0);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    check("rel_rdy", longint'(rdy[0]), 1);

    // LEN=4: four back-to-back beats close the frame on count.
    cyc(1, 100, 0, 0); cyc(1, 200, 0, 0); cyc(1, 300, 0, 0);
    check("t1_not_yet", longint'(vld[0]), 0);
    cyc(1, 400, 0, 0);
    check("t1_vld", longint'(vld[0]), 1);
    check("t1_sum", sum_of(0), 1000);
    check("t1_cnt", longint'(cnt[0]), 4);
    check("t1_sat", longint'(sat[0]), 0);

    // LEN=16: early close with in_last.
    do_reset();
    cyc(1, 7, 0, 0); cyc(1, 9, 1, 0);
    check("t2_vld", longint'(vld[1]), 1);
    check("t2_sum", sum_of(1), 16);
    check("t2_cnt", longint'(cnt[1]), 2);
    check("t2_rdy", longint'(rdy[1]), 0);

    // ACC_W=16, LEN=3: saturation.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 'h7FFF, 0, 0);
    check("t3_vld", longint'(vld[2]), 1);
    check("t3_sum", sum_of(2), 'hFFFF);
    check("t3_sat", longint'(sat[2]), 1);
    check("t3_cnt", longint'(cnt[2]), 3);

    // Backpressure on the saturated result, with a beat waiting upstream.
    held = sum_of(2);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 5, 1, 0);
      check("bp_vld", longint'(vld[2]), 1);
      check("bp_rdy", longint'(rdy[2]), 0);
      check("bp_sum", sum_of(2), held);
      check("bp_cnt", longint'(cnt[2]), 3);
    end
    cyc(1, 5, 1, 1);
    check("bp_take_vld", longint'(vld[2]), 0);
    check("bp_take_rdy", longint'(rdy[2]), 1);
    cyc(1, 5, 1, 0);
    check("bp_held_vld", longint'(vld[2]), 1);
    check("bp_held_sum", sum_of(2), 5);
    check("bp_held_cnt", longint'(cnt[2]), 1);
    check("bp_held_sat", longint'(sat[2]), 0);

    // Reset in the middle of a frame discards it.
    do_reset();
    cyc(1, 50, 0, 0); cyc(1, 50, 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    check("mr_rdy", longint'(rdy[1]), 0);
    check("mr_sum", sum_of(1), 0);
    check("mr_cnt", longint'(cnt[1]), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 10, 0, 0); cyc(1, 20, 1, 0);
    check("mr_vld", longint'(vld[1]), 1);
    check("mr_fsum", sum_of(1), 30);
    check("mr_fcnt", longint'(cnt[1]), 2);

    // LEN=256: full-length frame, no early close, no saturation.
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1, 'h7FFF, 0, 1);
    check("t6_early", longint'(vld[3]), 0);
    cyc(1, 'h7FFF, 0, 0);
    check("t6_vld", longint'(vld[3]), 1);
    check("t6_sum", sum_of(3), 8388352);
    check("t6_cnt", longint'(cnt[3]), 256);
    check("t6_sat", longint'(sat[3]), 0);

    // Random traffic; the model checker covers every cycle.
    for (int i = 0; i < 3000; i++) begin
      int p;
      rst_n = ($urandom_range(0, 199) != 0);
      p = ($urandom_range(0, 3) == 0) ? 'h7FFF : int'($urandom_range(0, 'h7FFF));
      cyc($urandom_range(0, 9) < 7, p, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
